// File: rtl/msrv32_dmem_slave.sv
// msrv32_dmem_slave: data-memory responder for the msrv32 AHB-lite-style data port.
// Word-organised SRAM model with byte-masked writes, WAIT_STATES hready-low cycles
// per data phase, and an optional two-cycle ERROR response for out-of-range
// addresses, enabled by defining MSRV32_DMEM_ERR_EN. Without that macro the word
// index wraps modulo the depth and hresp is tied to OKAY.
module msrv32_dmem_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_data_out,
  output logic        ms_riscv32_mp_data_hready_out,
  output logic        ms_riscv32_mp_hresp_out
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

`ifdef MSRV32_DMEM_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic {ST_IDLE, ST_DATA} state_t;
`endif

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  wr_q;
  logic [3:0]            mask_q;
  logic                  hready_q;
  logic [31:0]           data_q;

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] addr_idx;
  logic                  in_range;
  logic                  accept;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  unused_bits;

  // Address decode: byte offset from the base, word index is the offset >> 2.
  assign offset   = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign addr_idx = offset[ADDR_WIDTH+1:2];
`ifdef MSRV32_DMEM_ERR_EN
  assign in_range    = (offset[31:ADDR_WIDTH+2] == '0);
  assign unused_bits = ^{offset[1:0], ms_riscv32_mp_data_htrans_in[0]};
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0], ms_riscv32_mp_data_htrans_in[0]};
`endif

  // Address phase is taken only when the slave is ready and the master signals NONSEQ/SEQ.
  assign accept = hready_q & ms_riscv32_mp_data_htrans_in[1];
  // A write lands at the edge that closes its completion cycle.
  assign commit = (state == ST_DATA) && (cnt == 4'd0) && wr_q;

  // Read word selection: the latched index while still waiting, otherwise the
  // incoming address (zero-wait reads load at acceptance). A write committing on
  // the same edge to the same word is forwarded so read-after-write sees new data.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    rd_idx  = addr_idx;
    if ((state == ST_DATA) && (cnt != 4'd0)) rd_idx = idx_q;
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) rd_word[8*i +: 8] = ms_riscv32_mp_dmdata_in[8*i +: 8];
      end
    end
  end

  // Byte-masked memory write at the closing edge of a write data phase.
  // NOTE: the memory array has no reset; contents survive rst_n and only the control path is cleared.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= ms_riscv32_mp_dmdata_in[8*i +: 8];
      end
    end
  end

`ifdef MSRV32_DMEM_ERR_EN
  logic hresp_q;
`endif

  // Transfer FSM with registered hready/hresp/read data.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      mask_q   <= 4'd0;
      hready_q <= 1'b1;
      data_q   <= 32'd0;
`ifdef MSRV32_DMEM_ERR_EN
      hresp_q  <= 1'b0;
`endif
    end else if ((state == ST_DATA) && (cnt != 4'd0)) begin
      // Wait states: count down; the last one opens the completion cycle.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hready_q <= 1'b1;
        if (!wr_q) data_q <= rd_word;
      end
`ifdef MSRV32_DMEM_ERR_EN
    end else if (state == ST_ERR1) begin
      state    <= ST_ERR2;
      hready_q <= 1'b1;
      hresp_q  <= 1'b1;
`endif
    end else if (accept) begin
      // IDLE, ERR2 or a completing DATA phase: take the next address phase.
      idx_q  <= addr_idx;
      wr_q   <= ms_riscv32_mp_dmwr_req_in;
      mask_q <= ms_riscv32_mp_dmwr_mask_in;
      if (in_range) begin
        state    <= ST_DATA;
        cnt      <= WS;
        hready_q <= (WS == 4'd0);
        if ((WS == 4'd0) && !ms_riscv32_mp_dmwr_req_in) data_q <= rd_word;
`ifdef MSRV32_DMEM_ERR_EN
        hresp_q  <= 1'b0;
      end else begin
        state    <= ST_ERR1;
        hready_q <= 1'b0;
        hresp_q  <= 1'b1;
`endif
      end
    end else begin
      state    <= ST_IDLE;
      hready_q <= 1'b1;
`ifdef MSRV32_DMEM_ERR_EN
      hresp_q  <= 1'b0;
`endif
    end
  end

  assign ms_riscv32_mp_data_out        = data_q;
  assign ms_riscv32_mp_data_hready_out = hready_q;
`ifdef MSRV32_DMEM_ERR_EN
  assign ms_riscv32_mp_hresp_out       = hresp_q;
`else
  assign ms_riscv32_mp_hresp_out       = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_dmem_slave.sv
// Self-checking bench for msrv32_dmem_slave. Three instances with WAIT_STATES
// 1, 0 and 3 share one clock; inputs change on the falling edge and outputs are
// sampled there too, away from the rising edge the DUT uses.
module tb_msrv32_dmem_slave;

  logic        clk;
  logic        rst_n  [3];
  logic [31:0] dmaddr [3];
  logic        wr     [3];
  logic [3:0]  mask   [3];
  logic [1:0]  htrans [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        hready [3];
  logic        hresp  [3];

  logic [31:0] last_rd [3];
  int n_vec;
  int n_err;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  msrv32_dmem_slave #(.WAIT_STATES(1)) u_ws1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n[0]),
    .ms_riscv32_mp_dmaddr_in(dmaddr[0]), .ms_riscv32_mp_dmwr_req_in(wr[0]),
    .ms_riscv32_mp_dmwr_mask_in(mask[0]), .ms_riscv32_mp_data_htrans_in(htrans[0]),
    .ms_riscv32_mp_dmdata_in(wdata[0]), .ms_riscv32_mp_data_out(rdata[0]),
    .ms_riscv32_mp_data_hready_out(hready[0]), .ms_riscv32_mp_hresp_out(hresp[0]));

  msrv32_dmem_slave #(.WAIT_STATES(0)) u_ws0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n[1]),
    .ms_riscv32_mp_dmaddr_in(dmaddr[1]), .ms_riscv32_mp_dmwr_req_in(wr[1]),
    .ms_riscv32_mp_dmwr_mask_in(mask[1]), .ms_riscv32_mp_data_htrans_in(htrans[1]),
    .ms_riscv32_mp_dmdata_in(wdata[1]), .ms_riscv32_mp_data_out(rdata[1]),
    .ms_riscv32_mp_data_hready_out(hready[1]), .ms_riscv32_mp_hresp_out(hresp[1]));

  msrv32_dmem_slave #(.WAIT_STATES(3)) u_ws3 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n[2]),
    .ms_riscv32_mp_dmaddr_in(dmaddr[2]), .ms_riscv32_mp_dmwr_req_in(wr[2]),
    .ms_riscv32_mp_dmwr_mask_in(mask[2]), .ms_riscv32_mp_data_htrans_in(htrans[2]),
    .ms_riscv32_mp_dmdata_in(wdata[2]), .ms_riscv32_mp_data_out(rdata[2]),
    .ms_riscv32_mp_data_hready_out(hready[2]), .ms_riscv32_mp_hresp_out(hresp[2]));

  always #5 clk = ~clk;

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One NONSEQ transfer. Called at a falling edge with hready=1; returns at the
  // falling edge inside the completion cycle, so the next call pipelines onto it.
  task automatic xfer(input int inst, input logic w, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] d,
                      input logic [31:0] exp, input string tag);
    int waits;
    dmaddr[inst] = a;
    wr[inst]     = w;
    mask[inst]   = m;
    htrans[inst] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    htrans[inst] = 2'b00;
    wdata[inst]  = d;
    waits = 0;
    while (hready[inst] !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check({tag, " waits"}, 32'(waits), 32'(ws_of(inst)));
    check({tag, " hresp"}, {31'd0, hresp[inst]}, 32'd0);
    if (!w) last_rd[inst] = exp;
    check({tag, " data_out"}, rdata[inst], last_rd[inst]);
  endtask

  initial begin
    clk   = 1'b0;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; dmaddr[i] = '0; wr[i] = 1'b0; mask[i] = 4'h0;
      htrans[i] = 2'b00; wdata[i] = '0; last_rd[i] = '0;
    end

    vecs[0]  = '{1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h010, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h010, 4'h5, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b0, 32'h010, 4'hF, 32'h0,        32'hDE22BE44};
    vecs[4]  = '{1'b1, 32'h014, 4'hF, 32'h12345678, 32'h0};
    vecs[5]  = '{1'b1, 32'h014, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1'b0, 32'h014, 4'hF, 32'h0,        32'h12345678};
    vecs[7]  = '{1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1'b0, 32'hFFC, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[9]  = '{1'b1, 32'h000, 4'hF, 32'h0BADC0DE, 32'h0};
    vecs[10] = '{1'b0, 32'h000, 4'hF, 32'h0,        32'h0BADC0DE};
    vecs[11] = '{1'b0, 32'h013, 4'hF, 32'h0,        32'hDE22BE44};

    // Reset values while held in reset.
    #12;
    check("reset hready", {31'd0, hready[0]}, 32'd1);
    check("reset hresp",  {31'd0, hresp[0]},  32'd0);
    check("reset data",   rdata[0],           32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Table: writes/reads on the one-wait-state instance.
    for (int v = 0; v < 12; v++) begin
      xfer(0, vecs[v].wr, vecs[v].addr, vecs[v].mask, vecs[v].wdata, vecs[v].exp,
           $sformatf("vec%0d", v));
    end
    htrans[0] = 2'b00;
    @(negedge clk);

    // BUSY and IDLE with a write request must not touch memory.
    dmaddr[0] = 32'h010; wr[0] = 1'b1; mask[0] = 4'hF; wdata[0] = 32'h0;
    htrans[0] = 2'b01;
    @(posedge clk); @(negedge clk);
    check("busy hready", {31'd0, hready[0]}, 32'd1);
    check("busy hresp",  {31'd0, hresp[0]},  32'd0);
    htrans[0] = 2'b00;
    @(posedge clk); @(negedge clk);
    check("idle hready", {31'd0, hready[0]}, 32'd1);
    xfer(0, 1'b0, 32'h010, 4'hF, 32'h0, 32'hDE22BE44, "after busy/idle");

    // Out-of-range read.
`ifdef MSRV32_DMEM_ERR_EN
    dmaddr[0] = 32'h1000; wr[0] = 1'b0; htrans[0] = 2'b10;
    @(posedge clk); @(negedge clk);
    htrans[0] = 2'b00;
    check("err1 hready", {31'd0, hready[0]}, 32'd0);
    check("err1 hresp",  {31'd0, hresp[0]},  32'd1);
    @(negedge clk);
    check("err2 hready", {31'd0, hready[0]}, 32'd1);
    check("err2 hresp",  {31'd0, hresp[0]},  32'd1);
    check("err2 data",   rdata[0],           last_rd[0]);
    xfer(0, 1'b0, 32'h010, 4'hF, 32'h0, 32'hDE22BE44, "read from err2");
`else
    xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0BADC0DE, "wrap read");
`endif
    htrans[0] = 2'b00;

    // Zero-wait instance: back-to-back reads and pipelined read-after-write.
    xfer(1, 1'b1, 32'h010, 4'hF, 32'h0000000A, 32'h0, "ws0 pre A");
    xfer(1, 1'b1, 32'h014, 4'hF, 32'h0000000B, 32'h0, "ws0 pre B");
    dmaddr[1] = 32'h010; wr[1] = 1'b0; htrans[1] = 2'b10;
    @(posedge clk); @(negedge clk);
    check("b2b hready 1", {31'd0, hready[1]}, 32'd1);
    check("b2b data A",   rdata[1],           32'h0000000A);
    dmaddr[1] = 32'h014;
    @(posedge clk); @(negedge clk);
    check("b2b hready 2", {31'd0, hready[1]}, 32'd1);
    check("b2b data B",   rdata[1],           32'h0000000B);
    dmaddr[1] = 32'h018; wr[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    wdata[1] = 32'h0000000C;
    dmaddr[1] = 32'h018; wr[1] = 1'b0;
    check("raw hready", {31'd0, hready[1]}, 32'd1);
    check("raw hold B", rdata[1],           32'h0000000B);
    @(posedge clk); @(negedge clk);
    htrans[1] = 2'b00;
    check("raw data C", rdata[1], 32'h0000000C);
    last_rd[1] = 32'h0000000C;
    @(negedge clk);
    xfer(1, 1'b0, 32'h018, 4'hF, 32'h0, 32'h0000000C, "ws0 reread C");
    htrans[1] = 2'b00;

    // Three-wait instance: reset during the second wait cycle of a write.
    xfer(2, 1'b1, 32'h020, 4'hF, 32'h00000000, 32'h0, "ws3 pre 0x20");
    xfer(2, 1'b1, 32'h024, 4'hF, 32'h00000077, 32'h0, "ws3 pre 0x24");
    xfer(2, 1'b0, 32'h024, 4'hF, 32'h0,        32'h00000077, "ws3 read 0x24");
    dmaddr[2] = 32'h020; wr[2] = 1'b1; mask[2] = 4'hF; htrans[2] = 2'b10;
    @(posedge clk); @(negedge clk);
    htrans[2] = 2'b00;
    wdata[2]  = 32'h55555555;
    check("ws3 wait1 hready", {31'd0, hready[2]}, 32'd0);
    @(negedge clk);
    check("ws3 wait2 hready", {31'd0, hready[2]}, 32'd0);
    rst_n[2] = 1'b0;
    #1;
    check("midreset hready", {31'd0, hready[2]}, 32'd1);
    check("midreset hresp",  {31'd0, hresp[2]},  32'd0);
    check("midreset data",   rdata[2],           32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    last_rd[2] = 32'd0;
    @(negedge clk);
    xfer(2, 1'b0, 32'h020, 4'hF, 32'h0, 32'h00000000, "ws3 read 0x20");
    htrans[2] = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
